data_mem_be: RTL and testbench

Parametrised byte-addressable data memory for the MIPS datapath, the successor to the single-word data RAM. It adds byte, halfword and word loads and stores, with sign or zero extension on loads and byte-lane merging on stores. Reads are registered with a valid strobe, and misaligned or out-of-range accesses are flagged. After every reset a hardware sweep clears the whole array, and the block reports `ready` only when the sweep is done. It sits between the MEM stage and the register-file writeback mux.

---
 rtl/data_mem_be_pkg.sv | 26 ++
 rtl/data_mem_be_if.sv | 40 ++++
 rtl/data_mem_be_lane_align.sv | 67 ++++++
 rtl/data_mem_be.sv | 142 ++++++++++++++
 tb/tb_data_mem_be.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_be_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mips_mem_pkg                                                 |
// | Description : Shared encodings for the byte-enabled MIPS data memory:      |
// |               access-size codes, lane count and the sweep/run FSM state.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mips_mem_pkg;

  // Access size codes carried on the size bus.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Byte lanes per 32-bit word.
  localparam int c_num_lanes = 4;

  // CLEAR sweeps the array to zero after reset, RUN serves requests.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_be_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : data_mem_be_if                                               |
// | Description : Request/response bundle between the MEM stage and the data   |
// |               memory.                                                      |
// |   req        : access request, honoured only while ready = 1             |
// |   we         : 1 = store, 0 = load                                        |
// |   size       : 00 byte, 01 half, 10 word, 11 reserved                     |
// |   uns        : zero-extend (1) or sign-extend (0) narrow loads            |
// |   address    : byte address                                               |
// |   data_write : right-aligned store data                                   |
// |   data_out   : extended load result, holds between loads                  |
// |   rvalid     : one-cycle strobe, data_out freshly loaded                   |
// |   err        : one-cycle strobe, request rejected                         |
// |   ready      : memory idle and accepting requests                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface data_mem_be_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] address;
  logic [31:0] data_write;
  logic [31:0] data_out;
  logic        rvalid;
  logic        err;
  logic        ready;

  modport master (
    output req, we, size, uns, address, data_write,
    input  data_out, rvalid, err, ready
  );

  modport slave (
    input  req, we, size, uns, address, data_write,
    output data_out, rvalid, err, ready
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_be_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_lane_align                                              |
// | Description : Combinational byte-lane steering for the data memory.        |
// |   i_size       : access size code                                         |
// |   i_lane       : byte offset within the word (address[1:0])               |
// |   i_uns        : zero-extend narrow loads when 1                           |
// |   i_data_write : right-aligned store data                                 |
// |   i_rd_word    : word currently stored at the addressed index             |
// |   o_lane_we    : per-lane write enables for a store                       |
// |   o_wr_word    : store data replicated onto every candidate lane          |
// |   o_ld_data    : selected lane(s) extended to 32 bits                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_lane_align
  import mips_mem_pkg::*;
(
  input  wire logic [1:0]             i_size,
  input  wire logic [1:0]             i_lane,
  input  wire logic                   i_uns,
  input  wire logic [31:0]            i_data_write,
  input  wire logic [31:0]            i_rd_word,
  output logic      [c_num_lanes-1:0] o_lane_we,
  output logic      [31:0]            o_wr_word,
  output logic      [31:0]            o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_lane_we = '0;
    o_wr_word = i_data_write;
    o_ld_data = i_rd_word;

    case (i_lane)
      2'd0:    w_byte = i_rd_word[7:0];
      2'd1:    w_byte = i_rd_word[15:8];
      2'd2:    w_byte = i_rd_word[23:16];
      default: w_byte = i_rd_word[31:24];
    endcase
    w_half = i_lane[1] ? i_rd_word[31:16] : i_rd_word[15:0];

    // Store data is replicated across the word so the lane enables alone
    // decide which bytes land; no shift by the lane offset is needed.
    case (i_size)
      SZ_BYTE: begin
        o_lane_we = 4'b0001 << i_lane;
        o_wr_word = {4{i_data_write[7:0]}};
        o_ld_data = i_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_lane_we = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wr_word = {2{i_data_write[15:0]}};
        o_ld_data = i_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      SZ_WORD: begin
        o_lane_we = 4'b1111;
      end
      default: begin
        o_lane_we = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_be.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_be                                                  |
// | Description : Byte-addressable DEPTH x 32 data memory with byte/half/word  |
// |               loads and stores, registered reads, error flagging and a    |
// |               post-reset clearing sweep.                                   |
// |   clk   : clock, rising edge                                              |
// |   reset : synchronous active-high reset, restarts the clearing sweep      |
// |   bus   : request/response bundle (slave side)                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_mem_be
  import mips_mem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input wire logic     clk,
  input wire logic     reset,
  data_mem_be_if.slave bus
);

  localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

  logic [31:0]            r_mem [DEPTH];
  mem_state_t             r_state;
  mem_state_t             w_state_nxt;
  logic [AW-1:0]          r_clr_idx;
  logic [AW-1:0]          w_clr_idx_nxt;

  logic                   r_rvalid;
  logic                   r_err;
  logic [31:0]            r_data_out;

  logic                   w_run;
  logic                   w_accept;
  logic                   w_out_of_range;
  logic                   w_bad;
  logic                   w_store;
  logic                   w_load;
  logic [AW-1:0]          w_idx;
  logic [31:0]            w_rd_word;
  logic [c_num_lanes-1:0] w_lane_we;
  logic [31:0]            w_wr_word;
  logic [31:0]            w_ld_data;

  assign w_run     = (r_state == ST_RUN);
  assign w_idx     = bus.address[AW+1:2];
  assign w_rd_word = r_mem[w_idx];

  // Any address bit above the array's byte range makes the access illegal.
  assign w_out_of_range = |(bus.address >> (AW + 2));

  assign w_bad = (bus.size == SZ_RSVD)
               | ((bus.size == SZ_HALF) & bus.address[0])
               | ((bus.size == SZ_WORD) & (|bus.address[1:0]))
               | w_out_of_range;

  assign w_accept = bus.req & w_run & ~reset;
  assign w_store  = w_accept & bus.we & ~w_bad;
  assign w_load   = w_accept & ~bus.we & ~w_bad;

  dmem_lane_align u_align (
    .i_size       (bus.size),
    .i_lane       (bus.address[1:0]),
    .i_uns        (bus.uns),
    .i_data_write (bus.data_write),
    .i_rd_word    (w_rd_word),
    .o_lane_we    (w_lane_we),
    .o_wr_word    (w_wr_word),
    .o_ld_data    (w_ld_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Next state: sweep one word per cycle, then serve requests.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_idx == c_last_idx) begin
          w_state_nxt   = ST_RUN;
          w_clr_idx_nxt = '0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + 1'b1;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_idx_nxt = '0;
      end
    endcase
  end

  // Array: clearing writes during the sweep, per-lane writes for stores.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_store) begin
      for (int l = 0; l < c_num_lanes; l++) begin
        if (w_lane_we[l]) begin
          r_mem[w_idx][8*l +: 8] <= w_wr_word[8*l +: 8];
        end
      end
    end
  end

  // Response registers; data_out only moves on a successful load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_rvalid <= w_load;
      r_err    <= w_accept & w_bad;
      if (w_load) begin
        r_data_out <= w_ld_data;
      end
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.rvalid   = r_rvalid;
  assign bus.err      = r_err;
  assign bus.ready    = w_run;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_be.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_mem_be                                               |
// | Description : Self-checking bench for data_mem_be: byte-array reference    |
// |               model compared every cycle, directed literal expectations   |
// |               and randomized traffic.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_mem_be;
  import mips_mem_pkg::*;

  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic reset;
  data_mem_be_if bus ();

  data_mem_be #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain byte array plus expected response values.
  logic [7:0]  m_mem [NBYTES];
  int          m_clr_cnt = 0;
  bit          m_ready   = 1'b0;
  bit          m_started = 1'b0;
  logic        e_rvalid  = 1'b0;
  logic        e_err     = 1'b0;
  logic [31:0] e_dout    = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic bit illegal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'(NBYTES));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit u,
                                             input logic [31:0] a);
    logic [31:0] v;
    int i;
    i = int'(a);
    if (sz == 2'b00) begin
      v = {24'h0, m_mem[i]};
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = {16'h0, m_mem[i+1], m_mem[i]};
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = {m_mem[i+3], m_mem[i+2], m_mem[i+1], m_mem[i]};
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1'b1;
      m_ready   = 1'b0;
      m_clr_cnt = 0;
      e_rvalid  = 1'b0;
      e_err     = 1'b0;
      e_dout    = '0;
    end else if (m_started) begin
      e_rvalid = 1'b0;
      e_err    = 1'b0;
      if (m_ready && bus.req) begin
        if (illegal(bus.size, bus.address)) begin
          e_err = 1'b1;
        end else if (bus.we) begin
          for (int k = 0; k < (1 << bus.size); k++)
            m_mem[int'(bus.address) + k] = bus.data_write[8*k +: 8];
        end else begin
          e_rvalid = 1'b1;
          e_dout   = model_load(bus.size, bus.uns, bus.address);
        end
      end
      if (!m_ready) begin
        m_clr_cnt++;
        if (m_clr_cnt == DEPTH) begin
          m_ready = 1'b1;
          for (int k = 0; k < NBYTES; k++) m_mem[k] = 8'h00;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (m_started) begin
      chk("ready",    {31'h0, bus.ready},  {31'h0, m_ready});
      chk("rvalid",   {31'h0, bus.rvalid}, {31'h0, e_rvalid});
      chk("err",      {31'h0, bus.err},    {31'h0, e_err});
      chk("data_out", bus.data_out,        e_dout);
    end
  end

  task automatic drive(input bit rq, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req        = rq;
    bus.we         = w;
    bus.size       = sz;
    bus.uns        = u;
    bus.address    = a;
    bus.data_write = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
  endtask

  // Issue one access and check its response after the accepting edge.
  task automatic op(input string name, input bit w, input logic [1:0] sz, input bit u,
                    input logic [31:0] a, input logic [31:0] d,
                    input bit exp_err, input logic [31:0] exp_data);
    drive(1'b1, w, sz, u, a, d);
    @(posedge clk);
    #2;
    chk({name, "_err"}, {31'h0, bus.err}, {31'h0, exp_err});
    if (!exp_err && !w) begin
      chk({name, "_rvalid"}, {31'h0, bus.rvalid}, 32'h1);
      chk(name, bus.data_out, exp_data);
    end
  endtask

  task automatic release_and_count(input string name);
    int n;
    n = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ready) break;
    end
    chk(name, n, DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = SZ_WORD; bus.uns = 1'b0;
    bus.address = '0; bus.data_write = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    release_and_count("ready_latency");

    op("ld_fc", 1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h0000_0000);

    op("sb10", 1'b1, SZ_BYTE, 1'b0, 32'h10, 32'hAAAA_AA11, 1'b0, 32'h0);
    op("sb11", 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h5555_5522, 1'b0, 32'h0);
    op("sb12", 1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h0000_0033, 1'b0, 32'h0);
    op("sb13", 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hFFFF_FF84, 1'b0, 32'h0);
    op("lw10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8433_2211);
    op("lb13s", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF84);
    op("lb13u", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0000_0084);

    op("sw20", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1234_5678, 1'b0, 32'h0);
    op("sh22", 1'b1, SZ_HALF, 1'b0, 32'h22, 32'hAAAA_BEEF, 1'b0, 32'h0);
    op("lw20", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'hBEEF_5678);
    op("lh22s", 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 1'b0, 32'hFFFF_BEEF);
    op("lh20u", 1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0000_5678);

    op("e_lw06",  1'b0, SZ_WORD, 1'b0, 32'h06,  32'h0,         1'b1, 32'h0);
    op("e_sh01",  1'b1, SZ_HALF, 1'b0, 32'h01,  32'hFFFF_FFFF, 1'b1, 32'h0);
    op("e_sz11",  1'b1, SZ_RSVD, 1'b0, 32'h10,  32'hFFFF_FFFF, 1'b1, 32'h0);
    op("e_sw100", 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h0);
    op("keep00", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0000_0000);
    op("keep10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8433_2211);

    op("sw40", 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b0, 32'h0);
    op("lw40", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'hCAFE_F00D);
    op("b2b_a", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8433_2211);
    op("b2b_b", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'hBEEF_5678);
    op("b2b_c", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'hCAFE_F00D);
    idle();

    // Randomized traffic; the model comparison does the checking.
    for (int i = 0; i < 800; i++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom;
      end else begin
        a = 32'($urandom_range(0, 31));
        if ($urandom_range(0, 3) != 0) begin
          if (sz == SZ_HALF) a[0] = 1'b0;
          if (sz == SZ_WORD) a[1:0] = 2'b00;
        end
      end
      drive($urandom_range(0, 3) != 0, 1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    idle();

    // Reset in RUN, then again partway through the sweep.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    release_and_count("ready_after_midclear");
    op("cleared40", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0000_0000);

    // Reset arriving with a load pending.
    op("sw10b", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0000_0055, 1'b0, 32'h0);
    op("lw10b", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_0055);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = SZ_WORD; bus.address = 32'h10;
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_load_rvalid", {31'h0, bus.rvalid}, 32'h0);
    chk("rst_load_dout", bus.data_out, 32'h0);
    idle();
    release_and_count("ready_after_rst_load");

    repeat (2) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
